// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared ring-buffer definitions for the 4-slot tribit-pointer FIFO (read and write sides).
// Pointers carry a wrap bit above the slot address so that full and empty can be told apart.
package fifo_rd_ctrl_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 2;
  localparam int PTR_W      = ADDR_W_DEF + 1;
  localparam int DEPTH      = 1 << ADDR_W_DEF;

  typedef logic [PTR_W-1:0] ptr_t;

  function automatic logic ptr_empty(input ptr_t wr_ptr, input ptr_t rd_ptr);
    return wr_ptr == rd_ptr;
  endfunction

  // Full when the addresses match and only the wrap bits differ.
  function automatic logic ptr_full(input ptr_t wr_ptr, input ptr_t rd_ptr);
    return (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
           (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  endfunction

  function automatic ptr_t ptr_incr(input ptr_t ptr);
    return ptr + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Slot-RAM read port plus downstream valid/ready stream of the FIFO read controller.
// master = controller side, slave = RAM model / consumer side.
interface fifo_rd_ctrl_if
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [DATA_W-1:0] dout_data;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output ram_rd_en,
    output ram_rd_addr,
    input  ram_rd_data,
    output dout_data,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  ram_rd_en,
    input  ram_rd_addr,
    output ram_rd_data,
    input  dout_data,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/fifo_rd_outbuf.sv
// 2-entry output buffer: push at tail, pop at head, head word drives the stream.
// Registered head/count; a push and a pop may land in the same cycle.
module fifo_rd_outbuf #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic [1:0]        held_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              head_q, head_d;
  logic [1:0]        held_q, held_d;
  logic              tail;
  logic              pop_eff;

  assign pop_eff     = pop_i && (held_q != 2'd0);
  assign tail        = head_q ^ held_q[0];
  assign head_data_o = mem_q[head_q];
  assign held_o      = held_q;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    held_d = held_q;
    if (push_i) begin
      mem_d[tail] = push_data_i;
    end
    if (pop_eff) begin
      head_d = ~head_q;
    end
    case ({push_i, pop_eff})
      2'b10:   held_d = held_q + 2'd1;
      2'b01:   held_d = held_q - 2'd1;
      default: held_d = held_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      held_q   <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      held_q   <= held_d;
    end
  end

  // The read-issue credit rule in the parent must never let a third word in.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_eff && (held_q == 2'd2)));

  a_held_range: assert property (@(posedge clk) disable iff (rst)
    held_q != 2'd3);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the 4-slot ring buffer; FIFO_RD_OCCUPANCY_EN adds a registered rd_occupancy.
// Latency: pointer change -> ram_rd_en same cycle -> dout_valid two cycles later; issue stops after 2 unpopped words.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  ptr_t            wr_ptr_tribit,
  output ptr_t            rd_ptr_tribit,
  output logic            rd_greenflag,
`ifdef FIFO_RD_OCCUPANCY_EN
  output ptr_t            rd_occupancy,
`endif
  fifo_rd_ctrl_if.master  bus
);

  ptr_t              rd_ptr_q, rd_ptr_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        held;
  logic [2:0]        cnt;
  logic              pop;
  logic              rd_en;
  logic [DATA_W-1:0] head_data;

  assign rd_greenflag = !ptr_empty(wr_ptr_tribit, rd_ptr_q);
  assign pop          = bus.dout_valid && bus.dout_ready;

  // Words already owned by the read side once this cycle's pop is taken.
  assign cnt   = {1'b0, held} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en = rd_greenflag && (cnt < 3'd2) && !rst;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    inflight_d = rd_en;
    if (rd_en) begin
      rd_ptr_d = ptr_incr(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  fifo_rd_outbuf #(
    .DATA_W (DATA_W)
  ) u_outbuf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (bus.ram_rd_data),
    .pop_i       (pop),
    .head_data_o (head_data),
    .held_o      (held)
  );

  assign rd_ptr_tribit   = rd_ptr_q;
  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = rd_ptr_q[ADDR_W-1:0];
  assign bus.dout_valid  = (held != 2'd0);
  assign bus.dout_data   = head_data;

`ifdef FIFO_RD_OCCUPANCY_EN
  ptr_t occ_q, occ_d;

  // Slots still in RAM; words sitting in the output buffer are not counted.
  assign occ_d = wr_ptr_tribit - rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign rd_occupancy = occ_q;

  a_occ_range: assert property (@(posedge clk) disable iff (rst)
    occ_q <= ptr_t'(DEPTH));
`endif

  a_no_read_empty: assert property (@(posedge clk) disable iff (rst)
    bus.ram_rd_en |-> rd_greenflag);

  a_stream_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.dout_valid && !bus.dout_ready) |=> (bus.dout_valid && $stable(bus.dout_data)));

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;
  import fifo_rd_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ptr_t wr_ptr = '0;
  ptr_t rd_ptr_tribit;
  logic rd_greenflag;
`ifdef FIFO_RD_OCCUPANCY_EN
  ptr_t rd_occupancy;
`endif

  fifo_rd_ctrl_if bus ();

  fifo_rd_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .wr_ptr_tribit (wr_ptr),
`ifdef FIFO_RD_OCCUPANCY_EN
    .rd_occupancy  (rd_occupancy),
`endif
    .rd_ptr_tribit (rd_ptr_tribit),
    .rd_greenflag  (rd_greenflag),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: RAM contents, model read pointer, words owned by the
  // read side in delivery order, and the word travelling from the RAM.
  logic [63:0] mem [4];
  ptr_t        rdm = '0;
  logic [63:0] q [$];
  bit          infl = 1'b0;
  logic [63:0] infl_data = '0;
  ptr_t        occ_exp = '0;

  function automatic bit exp_rden();
    int pop;
    pop = (q.size() != 0 && bus.dout_ready) ? 1 : 0;
    return !rst && (wr_ptr != rdm) && ((q.size() + int'(infl) - pop) < 2);
  endfunction

  function automatic bit can_write();
    ptr_t diff;
    diff = wr_ptr - rdm;
    return diff < ptr_t'(4);
  endfunction

  task automatic cycle(input bit adv, input logic [63:0] d);
    bit          den, rden_m, pop_m;
    logic [1:0]  dadr;
    den    = bus.ram_rd_en;
    dadr   = bus.ram_rd_addr;
    rden_m = exp_rden();
    pop_m  = (q.size() != 0) && bus.dout_ready;
    @(posedge clk);
    #1;
    occ_exp = wr_ptr - rdm;
    bus.ram_rd_data = den ? mem[dadr] : {$urandom, $urandom};
    if (pop_m) void'(q.pop_front());
    if (infl) q.push_back(infl_data);
    infl = rden_m;
    if (rden_m) begin
      infl_data = mem[rdm[1:0]];
      rdm = rdm + ptr_t'(1);
    end
    if (adv) begin
      mem[wr_ptr[1:0]] = d;
      wr_ptr = wr_ptr + ptr_t'(1);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 64'd0);
    q.delete();
    infl    = 1'b0;
    rdm     = '0;
    wr_ptr  = '0;
    occ_exp = '0;
    rst     = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.dout_ready = 1'b0;
    do_reset();
    checks += 5;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.dout_valid); end
    if (bus.dout_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.dout_data); end
    if (rd_ptr_tribit !== 3'd0) begin errors++; $display("FAIL reset_rdptr: got %0d expected 0", rd_ptr_tribit); end
    if (bus.ram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rden: got %0b expected 0", bus.ram_rd_en); end
    if (rd_greenflag !== 1'b0) begin errors++; $display("FAIL reset_green: got %0b expected 0", rd_greenflag); end
`ifdef FIFO_RD_OCCUPANCY_EN
    checks++;
    if (rd_occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", rd_occupancy); end
`endif
  endtask

  task automatic test_first_word();
    bus.dout_ready = 1'b0;
    do_reset();
    cycle(1'b1, 64'hA5);
    #1;
    checks += 2;
    if (bus.ram_rd_en !== 1'b1) begin errors++; $display("FAIL first_rden: got %0b expected 1", bus.ram_rd_en); end
    if (bus.ram_rd_addr !== 2'd0) begin errors++; $display("FAIL first_addr: got %0d expected 0", bus.ram_rd_addr); end
    cycle(1'b0, 64'd0);
    checks += 2;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL first_early_valid: got %0b expected 0", bus.dout_valid); end
    if (rd_ptr_tribit !== 3'd1) begin errors++; $display("FAIL first_rdptr: got %0d expected 1", rd_ptr_tribit); end
    cycle(1'b0, 64'd0);
    checks += 2;
    if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %0b expected 1", bus.dout_valid); end
    if (bus.dout_data !== 64'hA5) begin errors++; $display("FAIL first_data: got %0h expected a5", bus.dout_data); end
    bus.dout_ready = 1'b1;
    cycle(1'b0, 64'd0);
    #1;
    checks++;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL first_drain: got %0b expected 0", bus.dout_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w [4];
    int n = 0;
    int first = -1;
    int last = -1;
    for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom};
    bus.dout_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.dout_valid === 1'b1) begin
        checks++;
        if (n >= 4 || bus.dout_data !== w[n]) begin
          errors++;
          $display("FAIL b2b_data: word %0d got %0h expected %0h", n, bus.dout_data, (n < 4) ? w[n] : 64'd0);
        end
        if (first < 0) first = c;
        last = c;
        n++;
      end
      cycle(c < 4, (c < 4) ? w[c] : 64'd0);
    end
    checks += 4;
    if (n != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", n); end
    if (last - first != 3) begin errors++; $display("FAIL b2b_gapless: span %0d expected 3", last - first); end
    if (rd_ptr_tribit !== 3'd4) begin errors++; $display("FAIL b2b_rdptr: got %0d expected 4", rd_ptr_tribit); end
    if (rd_greenflag !== 1'b0) begin errors++; $display("FAIL b2b_green: got %0b expected 0", rd_greenflag); end
  endtask

  task automatic test_backpressure();
    logic [63:0] w [4];
    int n = 0;
    int reads = 0;
    for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom};
    bus.dout_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.ram_rd_en === 1'b1) reads++;
      if (bus.dout_valid === 1'b1) begin
        checks++;
        if (bus.dout_data !== w[0]) begin errors++; $display("FAIL bp_stable: got %0h expected %0h", bus.dout_data, w[0]); end
      end
      cycle(c < 4, (c < 4) ? w[c] : 64'd0);
    end
    #1;
    checks += 4;
    if (reads != 2) begin errors++; $display("FAIL bp_reads: got %0d expected 2", reads); end
    if (rd_ptr_tribit !== 3'd2) begin errors++; $display("FAIL bp_rdptr: got %0d expected 2", rd_ptr_tribit); end
    if (bus.ram_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rden: got %0b expected 0", bus.ram_rd_en); end
    if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b expected 1", bus.dout_valid); end
    bus.dout_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.dout_valid === 1'b1) begin
        checks++;
        if (n >= 4 || bus.dout_data !== w[n]) begin
          errors++;
          $display("FAIL bp_order: word %0d got %0h expected %0h", n, bus.dout_data, (n < 4) ? w[n] : 64'd0);
        end
        n++;
      end
      cycle(1'b0, 64'd0);
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", n); end
  endtask

  task automatic test_wrap();
    bus.dout_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 7; c++) cycle(1'b1, {$urandom, $urandom});
    for (int c = 0; c < 6; c++) cycle(1'b0, 64'd0);
    #1;
    checks++;
    if (rd_ptr_tribit !== 3'd7) begin errors++; $display("FAIL wrap_start: got %0d expected 7", rd_ptr_tribit); end
    cycle(1'b1, 64'hC0FFEE);
    #1;
    checks += 3;
    if (wr_ptr !== 3'd0) begin errors++; $display("FAIL wrap_wrptr: got %0d expected 0", wr_ptr); end
    if (bus.ram_rd_en !== 1'b1) begin errors++; $display("FAIL wrap_rden: got %0b expected 1", bus.ram_rd_en); end
    if (bus.ram_rd_addr !== 2'd3) begin errors++; $display("FAIL wrap_addr: got %0d expected 3", bus.ram_rd_addr); end
    cycle(1'b0, 64'd0);
    checks += 2;
    if (rd_ptr_tribit !== 3'd0) begin errors++; $display("FAIL wrap_rdptr: got %0d expected 0", rd_ptr_tribit); end
    if (rd_greenflag !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %0b expected 0", rd_greenflag); end
    cycle(1'b0, 64'd0);
    checks += 2;
    if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %0b expected 1", bus.dout_valid); end
    if (bus.dout_data !== 64'hC0FFEE) begin errors++; $display("FAIL wrap_data: got %0h expected c0ffee", bus.dout_data); end
    cycle(1'b0, 64'd0);
  endtask

  task automatic test_reset_mid();
    bus.dout_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 3; c++) cycle(1'b1, {$urandom, $urandom});
    do_reset();
    checks += 3;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b expected 0", bus.dout_valid); end
    if (rd_ptr_tribit !== 3'd0) begin errors++; $display("FAIL rstmid_rdptr: got %0d expected 0", rd_ptr_tribit); end
    if (rd_greenflag !== 1'b0) begin errors++; $display("FAIL rstmid_green: got %0b expected 0", rd_greenflag); end
    bus.dout_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 64'd0);
      checks++;
      if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: cycle %0d got valid %0b expected 0", c, bus.dout_valid); end
    end
  endtask

  task automatic test_random();
    bit adv;
    bus.dout_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks += 5;
      if (rd_ptr_tribit !== rdm) begin errors++; $display("FAIL rnd_rdptr: cycle %0d got %0d expected %0d", c, rd_ptr_tribit, rdm); end
      if (rd_greenflag !== (wr_ptr != rdm)) begin errors++; $display("FAIL rnd_green: cycle %0d got %0b expected %0b", c, rd_greenflag, wr_ptr != rdm); end
      if (bus.ram_rd_en !== exp_rden()) begin errors++; $display("FAIL rnd_rden: cycle %0d got %0b expected %0b", c, bus.ram_rd_en, exp_rden()); end
      if (bus.ram_rd_addr !== rdm[1:0]) begin errors++; $display("FAIL rnd_addr: cycle %0d got %0d expected %0d", c, bus.ram_rd_addr, rdm[1:0]); end
      if (bus.dout_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid: cycle %0d got %0b expected %0b", c, bus.dout_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++;
        if (bus.dout_data !== q[0]) begin errors++; $display("FAIL rnd_data: cycle %0d got %0h expected %0h", c, bus.dout_data, q[0]); end
      end
`ifdef FIFO_RD_OCCUPANCY_EN
      checks++;
      if (rd_occupancy !== occ_exp) begin errors++; $display("FAIL rnd_occ: cycle %0d got %0d expected %0d", c, rd_occupancy, occ_exp); end
`endif
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        adv = can_write() && ($urandom_range(0, 2) != 0);
        cycle(adv, {$urandom, $urandom});
      end
    end
  endtask

  initial begin
    bus.dout_ready  = 1'b0;
    bus.ram_rd_data = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    @(negedge clk);
    test_reset();
    test_first_word();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
